// File: rtl/dp_share_scheduler.sv
// Round-robin scheduler sharing one 3-stage compare/compute datapath among N requesters.
// Holds the winner's operands for SETTLE clocks, then returns the captured result tagged with its ID.
module dp_share_scheduler #(
  parameter int N      = 4,
  parameter int SETTLE = 3,
  localparam int IDW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   req_a,
  input  logic [8*N-1:0]   req_b,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic [7:0]       dp_a,
  output logic [7:0]       dp_b,
  input  logic [7:0]       dp_result,
  output logic             resp_valid,
  output logic [IDW-1:0]   resp_id,
  output logic [7:0]       resp_data
);

  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {IDLE, RUN, CAPT} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] rr_ptr, rr_ptr_n;
  logic [IDW-1:0] cur_id, cur_id_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [7:0]     dp_a_n, dp_b_n;
  logic [N-1:0]   gnt_n;
  logic           resp_valid_n;
  logic [IDW-1:0] resp_id_n;
  logic [7:0]     resp_data_n;

  logic [N-1:0]   req_rot;
  logic [IDW-1:0] offset;
  logic [IDW-1:0] winner;
  logic [IDW:0]   wsum;
  logic           found;

  // Rotate requests so bit 0 is the requester at rr_ptr; the lowest set bit is the winner's offset.
  assign req_rot = N'({req, req} >> rr_ptr);

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        found  = 1'b1;
        offset = IDW'(k);
      end
    end
  end

  assign wsum   = {1'b0, rr_ptr} + {1'b0, offset};
  assign winner = (wsum >= (IDW+1)'(N)) ? IDW'(wsum - (IDW+1)'(N)) : wsum[IDW-1:0];

  always_comb begin
    state_n      = state;
    rr_ptr_n     = rr_ptr;
    cur_id_n     = cur_id;
    cnt_n        = cnt;
    dp_a_n       = dp_a;
    dp_b_n       = dp_b;
    gnt_n        = '0;
    resp_valid_n = 1'b0;
    resp_id_n    = resp_id;
    resp_data_n  = resp_data;

    case (state)
      IDLE: begin
        if (found) begin
          dp_a_n        = req_a[{winner, 3'b000} +: 8];
          dp_b_n        = req_b[{winner, 3'b000} +: 8];
          cur_id_n      = winner;
          gnt_n[winner] = 1'b1;
          rr_ptr_n      = (winner == IDW'(N - 1)) ? '0 : winner + IDW'(1);
          cnt_n         = '0;
          state_n       = RUN;
        end
      end
      // Operands stay frozen here while the datapath register chain flushes.
      RUN: begin
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(SETTLE - 1)) begin
          state_n = CAPT;
        end
      end
      CAPT: begin
        resp_data_n  = dp_result;
        resp_id_n    = cur_id;
        resp_valid_n = 1'b1;
        state_n      = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_id     <= '0;
      cnt        <= '0;
      dp_a       <= '0;
      dp_b       <= '0;
      gnt        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_ptr_n;
      cur_id     <= cur_id_n;
      cnt        <= cnt_n;
      dp_a       <= dp_a_n;
      dp_b       <= dp_b_n;
      gnt        <= gnt_n;
      resp_valid <= resp_valid_n;
      resp_id    <= resp_id_n;
      resp_data  <= resp_data_n;
    end
  end

  // The response cycle itself still counts as busy, even though the FSM is already back in IDLE.
  assign busy = (state != IDLE) || resp_valid;

endmodule
